// File: rtl/push_btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// default timing constants.
package push_btn_pkg;

  localparam int PUSH_BTN_WAIT = 40000;
  localparam int PUSH_BTN_SIZE = 16;

  typedef enum logic [1:0] {
    PUSH_BTN_DEB_IDLE = 2'd0,
    PRESS_WAIT        = 2'd1,
    HELD              = 2'd2,
    RELEASE_WAIT      = 2'd3
  } push_btn_state_t;

endpackage

// File: rtl/push_btn_debouncer_if.sv
// Pin-side bundle of the debouncer: raw button in, debounced pulse and level out.
interface push_btn_debouncer_if;

  logic button;
  logic button_pressed;
  logic button_level;

  modport master (
    output button,
    input  button_pressed,
    input  button_level
  );

  modport slave (
    input  button,
    output button_pressed,
    output button_level
  );

endinterface

// File: rtl/push_btn_sync.sv
// Two-flop synchroniser for an asynchronous pin; both stages clear to 0 on reset.
module push_btn_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/push_btn_debouncer.sv
// Debounces a raw push-button pin: one-cycle pulse per accepted press plus a
// debounced level. An edge is accepted only after Wait+1 consecutive equal samples.
module push_btn_debouncer
  import push_btn_pkg::*;
#(
  parameter int Wait = PUSH_BTN_WAIT,
  parameter int Size = PUSH_BTN_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  push_btn_debouncer_if.slave   bus
);

  localparam logic [Size-1:0] LastCount = Size'(Wait - 1);

  push_btn_state_t state;
  logic [Size-1:0] count;
  logic            s;
  logic            pressed_q;
  logic            level_q;

  push_btn_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.button),
    .q     (s)
  );

  // Any opposite sample inside a wait window drops back to the stable state,
  // so the full window must restart from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PUSH_BTN_DEB_IDLE;
      count     <= '0;
      pressed_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      pressed_q <= 1'b0;
      case (state)
        PUSH_BTN_DEB_IDLE: begin
          level_q <= 1'b0;
          count   <= '0;
          if (s) begin
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state   <= PUSH_BTN_DEB_IDLE;
            count   <= '0;
            level_q <= 1'b0;
          end else if (count == LastCount) begin
            state     <= HELD;
            count     <= '0;
            pressed_q <= 1'b1;
            level_q   <= 1'b1;
          end else begin
            count   <= count + Size'(1);
            level_q <= 1'b0;
          end
        end
        HELD: begin
          level_q <= 1'b1;
          count   <= '0;
          if (!s) begin
            state <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state   <= HELD;
            count   <= '0;
            level_q <= 1'b1;
          end else if (count == LastCount) begin
            state   <= PUSH_BTN_DEB_IDLE;
            count   <= '0;
            level_q <= 1'b0;
          end else begin
            count   <= count + Size'(1);
            level_q <= 1'b1;
          end
        end
        default: begin
          state   <= PUSH_BTN_DEB_IDLE;
          count   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.button_pressed = pressed_q;
  assign bus.button_level   = level_q;

endmodule

// File: tb/tb_push_btn_debouncer.sv
// Self-checking bench for push_btn_debouncer with Wait=4, Size=3, using a
// run-length reference model and an expected-output queue.
module tb_push_btn_debouncer;

  localparam int Wait = 4;
  localparam int Size = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  push_btn_debouncer_if bus ();

  push_btn_debouncer #(.Wait(Wait), .Size(Size)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [1:0] expQ[$];

  // Reference: level flips once Wait+1 consecutive synchronised samples differ from it.
  logic mSync1 = 1'b0;
  logic mS     = 1'b0;
  logic mLvl   = 1'b0;
  logic mPulse = 1'b0;
  int   run    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    mSync1 = 1'b0;
    mS     = 1'b0;
    mLvl   = 1'b0;
    mPulse = 1'b0;
    run    = 0;
  endtask

  task automatic modelStep(input logic b);
    if (!reset) begin
      clearModel();
    end else begin
      mPulse = 1'b0;
      if (mS != mLvl) begin
        run++;
        if (run == Wait + 1) begin
          mLvl   = ~mLvl;
          run    = 0;
          mPulse = mLvl;
        end
      end else begin
        run = 0;
      end
      mS     = mSync1;
      mSync1 = b;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic b, input logic rst, input int n);
    logic [1:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.button = b;
      reset      = rst;
      @(posedge clock);
      modelStep(b);
      expQ.push_back({mPulse, mLvl});
      #1;
      exp = expQ.pop_front();
      checkOutput(tag, {30'd0, bus.button_pressed, bus.button_level}, {30'd0, exp});
      if (bus.button_pressed === 1'b1) pulses++;
    end
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic assertResetNow(input string tag);
    #1;
    reset = 1'b0;
    clearModel();
    #1;
    checkOutput(tag, {30'd0, bus.button_pressed, bus.button_level}, 32'd0);
  endtask

  initial begin
    bus.button = 1'b0;

    applyStimulus("rst", 1'b0, 1'b0, 3);
    applyStimulus("idle", 1'b0, 1'b1, 50);
    checkOutput("idleCnt", pulses, 0);

    pulses = 0;
    applyStimulus("press", 1'b1, 1'b1, 110);
    checkOutput("pressCnt", pulses, 1);

    pulses = 0;
    applyStimulus("release", 1'b0, 1'b1, 20);
    checkOutput("releaseCnt", pulses, 0);
    applyStimulus("repress", 1'b1, 1'b1, 20);
    checkOutput("repressCnt", pulses, 1);

    pulses = 0;
    applyStimulus("glitch", 1'b0, 1'b1, 2);
    applyStimulus("glitch", 1'b1, 1'b1, 20);
    checkOutput("glitchCnt", pulses, 0);

    applyStimulus("rel2", 1'b0, 1'b1, 20);
    pulses = 0;
    applyStimulus("bounce", 1'b1, 1'b1, 3);
    applyStimulus("bounce", 1'b0, 1'b1, 1);
    applyStimulus("bounce", 1'b1, 1'b1, 20);
    checkOutput("bounceCnt", pulses, 1);

    applyStimulus("rel3", 1'b0, 1'b1, 20);
    pulses = 0;
    applyStimulus("prePw", 1'b1, 1'b1, 4);
    assertResetNow("rstPw");
    applyStimulus("inRst", 1'b1, 1'b0, 3);
    applyStimulus("postRst", 1'b1, 1'b1, 20);
    checkOutput("postRstCnt", pulses, 1);

    assertResetNow("rstHeld");
    applyStimulus("inRst2", 1'b0, 1'b0, 2);
    applyStimulus("end", 1'b0, 1'b1, 5);

    checkOutput("sbEmpty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/push_btn_debouncer.md
# push_btn_debouncer

- Sits directly upstream of the push-button instruction unit.
- Takes the raw, asynchronous, bouncing button pin and synchronises it to `clock`.
- Filters it with a stable-time counter and emits a single-cycle `button_pressed` pulse per confirmed press, plus a debounced level.
- The downstream unit ORs the pulse into its sticky status bit, so the pulse must never repeat while the button stays held.

## Interface
Parameters:
- `Wait`, 40000: number of consecutive stable synchronised samples, minus one, required to accept an edge; legal range 2 ≤ Wait < 2^Size.
- `Size`, 16: counter width in bits.

Ports:
- `clock`  input  1  single system clock; all flops on rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0); clears every flop immediately, release is seen on the next `clock` edge.
- `button`  input  1  raw pin, asynchronous to `clock`, active-high, may bounce.
- `button_pressed`  output  1  registered; high for exactly one cycle per accepted press.
- `button_level`  output  1  registered debounced level; 1 while the button is accepted as held.

## Operation
- Synchroniser: two flops, `sync1 <= button`, `s <= sync1`, both reset to 0. Only `s` feeds the FSM.
- Counter `count[Size-1:0]`, reset 0. It is cleared on every state change and on every bounce abort.
- FSM states:
  - Idle (stable released): `s`=1 → PressWait, count=0; else stay.
  - PressWait: `s`=0 → Idle, count=0, no pulse. `s`=1 and count==Wait-1 → Held, `button_pressed`<=1. Otherwise count+1.
  - Held (stable pressed): `s`=0 → ReleaseWait, count=0; else stay.
  - ReleaseWait: `s`=1 → Held, count=0, no pulse. `s`=0 and count==Wait-1 → Idle. Otherwise count+1.
- Unreachable encodings → Idle, count=0, outputs 0. No error state; the block always recovers.
- `button_pressed` <= 1 only on the PressWait→Held transition, 0 in every other cycle.
- `button_level` <= 1 when the next state is Held or ReleaseWait, 0 otherwise.
- Release produces no pulse. A full release-debounce must complete before the next press can be accepted.
- Counter never exceeds Wait-1; no wrap is possible.
- Reset values: state Idle, count 0, `sync1`/`s` 0, `button_pressed` 0, `button_level` 0.

## Timing
- Press latency:
  - `button` first sampled 1 at edge E0 and held.
  - `s`=1 after E1; PressWait entered at E2.
  - Held entered at edge E(Wait+2).
  - `button_pressed` is high during the cycle after E(Wait+2), low again after E(Wait+3).
- Release latency: the same, Wait+2 edges to Idle. `button_level` falls in the cycle after that edge.
- Any single `s` sample of the opposite value inside a Wait window aborts the window. The full Wait+1-sample window then restarts from count 0.
- Reset asserted mid-PressWait: state aborts, no pulse, outputs 0 immediately (asynchronous).
- Button held through reset release: the synchroniser restarts at 0, so the press is re-qualified. One pulse at edge Wait+2 after the first post-reset edge that samples 1.
- Pulse width is always exactly one cycle; two pulses are separated by at least 2·(Wait+1) cycles.

## Structure
- Shared package `push_btn_pkg`:
  - 2-bit state encodings `PUSH_BTN_DEB_IDLE`=0, `PRESS_WAIT`=1, `HELD`=2, `RELEASE_WAIT`=3.
  - Default `Wait`/`Size` constants.
- One natural sub-module, `push_btn_sync`: two-flop synchroniser with async active-low reset. It is reused by other pin-input blocks.
- Counter and FSM stay in `push_btn_debouncer`; this totals ~150–200 lines of RTL.

## Test plan
All tests use `Wait`=4, `Size`=3.
- Reset release, `button`=0 for 50 cycles → `button_pressed`=0 and `button_level`=0 throughout.
- `button` rises at E0 and stays high → `button_pressed` high only in the cycle after E6; `button_level` 1 from then on; no further pulse over 100 held cycles.
- Bounce: `button` 1 for 3 cycles, 0 for 1, then 1 steady → no pulse from the first burst; a single pulse 6 edges after the final rise is sampled.
- Release after hold: `button` falls at E0 → `button_level` drops after E6; no pulse. A new press held long enough → exactly one new pulse.
- Release glitch: in Held, `button` 0 for 2 cycles then back to 1 → `button_level` stays 1, no pulse.
- Reset (0) asserted 2 cycles into PressWait with `button` still high → outputs 0 immediately; after release, one pulse 6 edges after the first sampling edge.
